sync_fifo: RTL and testbench
============================

# sync_fifo

Synchronous first-word-fall-through (FWFT) FIFO that sits between the UART receive side and the UART transmit side of the loopback test design. The FIFO controller writes into it through wr_en/wr_data and drains it through rd_en/rd_data. rd_data always shows the head entry, so the controller can sample it in the same cycle it asserts rd_en. The FIFO also provides full/empty, almost-full/almost-empty, an occupancy count, and sticky overflow/underflow error flags.

## Interface
- DATA_BITS, 8, width of each entry
- ADDR_BITS, 4, log2 of depth (depth = 2**ADDR_BITS = 16)
- AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
- clk_in  input  1  clock, all logic on rising edge
- n_rst  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous clear of pointers, count and error flags
- wr_en  input  1  push request
- wr_data  input  DATA_BITS  push data
- rd_en  input  1  pop request
- rd_data  output  DATA_BITS  head entry (FWFT)
- full  output  1  count == depth
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL
- almost_empty  output  1  count <= AE_LEVEL
- count  output  ADDR_BITS+1  current occupancy, 0..depth
- overflow  output  1  sticky: push attempted while full
- underflow  output  1  sticky: pop attempted while empty

## Operation
- Storage: register array of depth entries. Read is combinational at rd_ptr: rd_data = mem[rd_ptr[ADDR_BITS-1:0]].
- Pointers: wr_ptr and rd_ptr are ADDR_BITS+1 bits wide and wrap modulo 2**(ADDR_BITS+1).
  - count = wr_ptr - rd_ptr, computed at ADDR_BITS+1 width.
  - empty when the pointers are equal.
  - full when the MSBs differ and the lower bits are equal.
- Push accept: wr_en && !full. The entry is written to mem at wr_ptr and wr_ptr increments.
- Pop accept: rd_en && !empty. rd_ptr increments. The popped data is whatever rd_data showed in that cycle.
- Acceptance uses the current registered full/empty, not the next-cycle values:
  - When full, a push is rejected even if a pop is accepted in the same cycle.
  - When empty, a pop is rejected even if a push is accepted in the same cycle.
- Both accepted in the same cycle: count is unchanged; both pointers advance.
- Rejected push sets overflow. Rejected pop sets underflow. The rejected operation changes no state; data is dropped.
- Sticky flags are cleared only by flush or reset.
- Flush has priority over wr_en/rd_en in the same cycle:
  - Pointers, count and flags go to 0.
  - mem contents are retained.
- Reset (asynchronous, including mid-operation) clears all of the following:
  - pointers and mem, all to 0
  - rd_data = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, count = 0, overflow = 0, underflow = 0

## Timing
- All state updates happen on the rising edge of clk_in.
- Write-to-read latency: 1 cycle. After a push into an empty FIFO at edge N, empty = 0 and rd_data = the pushed word from just after edge N.
- After a pop at edge N, rd_data shows the next entry just after edge N.
- All flags and count are registered state or functions of registered pointers. They have no combinational path from wr_en/rd_en.
- Sustained throughput is one push and one pop per cycle.

## Structure
- Shared package/header holds:
  - default DATA_BITS/ADDR_BITS
  - the ASCII command constants "w" and "r" used by the controller
- One natural sub-module, fifo_regfile: parameterised register array with a synchronous write port, a combinational read port and an async reset.
- Pointer, flag and count logic lives in sync_fifo.

## Test plan
- Reset then idle: all outputs at reset values; rd_en pulse sets underflow = 1 and leaves count = 0.
- Push 0x00..0x0F in 16 cycles: full = 1 and count = 16 after the 16th edge; almost_full rises when count reaches 14; an extra push sets overflow and leaves the contents unchanged.
- Pop all 16 entries: rd_data sequence 0x00..0x0F, one per cycle; empty = 1 after the last pop; almost_empty asserts when count reaches 2.
- Simultaneous push/pop at count = 5 for 40 cycles: count stays 5; pointers wrap; data order is preserved.
- Push and pop in the same cycle while empty: push accepted, pop rejected; underflow = 1; rd_data = the pushed word next cycle.
- Flush at count = 7 together with a push: count = 0, empty = 1, flags cleared, push ignored; assert n_rst mid-burst → immediate return to reset values.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and controller command constants for the loopback FIFO.
package sync_fifo_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam int ADDR_BITS_DEF = 4;
  localparam int AF_LEVEL_DEF  = 14;
  localparam int AE_LEVEL_DEF  = 2;

  // ASCII commands the loopback controller decodes from the UART stream.
  typedef enum logic [7:0] {
    CMD_WRITE = 8'h77,  // "w"
    CMD_READ  = 8'h72   // "r"
  } cmd_e;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between the FIFO controller and the FIFO.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
);

  logic                 flush;
  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 rd_en;
  logic [DATA_BITS-1:0] rd_data;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [ADDR_BITS:0]   count;
  logic                 overflow;
  logic                 underflow;

  // Controller side: issues requests, observes data and status.
  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  // FIFO side: serves requests, reports data and status.
  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

endinterface : sync_fifo_if

// File: rtl/fifo_regfile.sv
// Register array: one synchronous write port, one combinational read port.
module fifo_regfile
  import sync_fifo_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                 clk_in,
  input  logic                 n_rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  // Write the addressed entry; reset clears every entry.
  // NOTE: the array is reset on purpose so rd_data reads 0 after reset;
  // this rules out a RAM macro, which suits a 16-entry register file.
  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : fifo_regfile

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with level flags and sticky errors.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int AF_LEVEL  = AF_LEVEL_DEF,
  parameter int AE_LEVEL  = AE_LEVEL_DEF
) (
  input  logic        clk_in,
  input  logic        n_rst,
  sync_fifo_if.slave  bus
);

  localparam logic [ADDR_BITS:0] PTR_ONE = 1;
  localparam logic [ADDR_BITS:0] AF_CNT  = AF_LEVEL[ADDR_BITS:0];
  localparam logic [ADDR_BITS:0] AE_CNT  = AE_LEVEL[ADDR_BITS:0];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_BITS:0] wr_ptr;
  logic [ADDR_BITS:0] rd_ptr;
  logic [ADDR_BITS:0] count;
  logic               full;
  logic               empty;
  logic               push_ok;
  logic               pop_ok;
  logic               overflow;
  logic               underflow;

  // Status derives only from registered pointers, never from the requests.
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                 (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);

  // Acceptance looks at this cycle's full/empty, so a simultaneous pop
  // cannot make room for a push into a full FIFO (and vice versa).
  assign push_ok = bus.wr_en && !full;
  assign pop_ok  = bus.rd_en && !empty;

  // Advance pointers on accepted operations and latch rejected ones as errors.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok)              wr_ptr    <= wr_ptr + PTR_ONE;
      if (pop_ok)               rd_ptr    <= rd_ptr + PTR_ONE;
      if (bus.wr_en && full)    overflow  <= 1'b1;
      if (bus.rd_en && empty)   underflow <= 1'b1;
    end
  end

  fifo_regfile #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_regfile (
    .clk_in (clk_in),
    .n_rst  (n_rst),
    .we     (push_ok && !bus.flush),
    .waddr  (wr_ptr[ADDR_BITS-1:0]),
    .wdata  (bus.wr_data),
    .raddr  (rd_ptr[ADDR_BITS-1:0]),
    .rdata  (bus.rd_data)
  );

  assign bus.count        = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= AF_CNT);
  assign bus.almost_empty = (count <= AE_CNT);
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk_in = 1'b0;
  logic n_rst  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  sync_fifo_if #(.DATA_BITS(DW), .ADDR_BITS(AW)) bus ();

  sync_fifo #(
    .DATA_BITS (DW),
    .ADDR_BITS (AW),
    .AF_LEVEL  (14),
    .AE_LEVEL  (2)
  ) dut (
    .clk_in (clk_in),
    .n_rst  (n_rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored words plus two sticky bits.
  logic [DW-1:0] mq[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  always @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      mq.delete();
      m_ovf <= 1'b0;
      m_unf <= 1'b0;
    end else if (bus.flush) begin
      mq.delete();
      m_ovf <= 1'b0;
      m_unf <= 1'b0;
    end else begin
      if (bus.wr_en && mq.size() == DEPTH) m_ovf <= 1'b1;
      if (bus.rd_en && mq.size() == 0)     m_unf <= 1'b1;
      if (bus.rd_en && mq.size() != 0 && bus.wr_en && mq.size() != DEPTH) begin
        void'(mq.pop_front());
        mq.push_back(bus.wr_data);
      end else if (bus.rd_en && mq.size() != 0) begin
        void'(mq.pop_front());
      end else if (bus.wr_en && mq.size() != DEPTH) begin
        mq.push_back(bus.wr_data);
      end
    end
  end

  // Compare DUT status and head data against the model away from the edge.
  always @(negedge clk_in) begin
    check("m_count", 32'(bus.count), 32'(mq.size()));
    check("m_empty", 32'(bus.empty), 32'(mq.size() == 0));
    check("m_full",  32'(bus.full),  32'(mq.size() == DEPTH));
    check("m_afull", 32'(bus.almost_full),  32'(mq.size() >= 14));
    check("m_aempty", 32'(bus.almost_empty), 32'(mq.size() <= 2));
    check("m_ovf", 32'(bus.overflow),  32'(m_ovf));
    check("m_unf", 32'(bus.underflow), 32'(m_unf));
    if (mq.size() != 0) check("m_rd_data", 32'(bus.rd_data), 32'(mq[0]));
  end

  // One clock of stimulus: apply at negedge, return just after the posedge.
  task automatic drive(input logic wr, input logic [DW-1:0] d,
                       input logic rd, input logic fl);
    @(negedge clk_in);
    bus.wr_en   = wr;
    bus.wr_data = d;
    bus.rd_en   = rd;
    bus.flush   = fl;
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_data"}, 32'(bus.rd_data), 32'h0);
    check({tag, "_empty"},   32'(bus.empty), 32'h1);
    check({tag, "_full"},    32'(bus.full), 32'h0);
    check({tag, "_aempty"},  32'(bus.almost_empty), 32'h1);
    check({tag, "_afull"},   32'(bus.almost_full), 32'h0);
    check({tag, "_count"},   32'(bus.count), 32'h0);
    check({tag, "_ovf"},     32'(bus.overflow), 32'h0);
    check({tag, "_unf"},     32'(bus.underflow), 32'h0);
  endtask

  initial begin
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;

    // Reset then idle.
    #12;
    check_reset_values("reset");
    @(negedge clk_in);
    n_rst = 1'b1;
    drive(0, 8'h00, 0, 0);
    check_reset_values("idle");

    // Pop from empty: underflow sticks, count stays 0.
    drive(0, 8'h00, 1, 0);
    check("unf_set", 32'(bus.underflow), 32'h1);
    check("unf_count", 32'(bus.count), 32'h0);
    drive(0, 8'h00, 0, 0);
    check("unf_sticky", 32'(bus.underflow), 32'h1);
    drive(0, 8'h00, 0, 1);
    check("unf_flushed", 32'(bus.underflow), 32'h0);

    // Fill with 0x00..0x0F.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, DW'(i), 0, 0);
      if (i == 0)  check("fill_first_rd", 32'(bus.rd_data), 32'h00);
      if (i == 0)  check("fill_first_empty", 32'(bus.empty), 32'h0);
      if (i == 12) check("af_at13", 32'(bus.almost_full), 32'h0);
      if (i == 13) check("af_at14", 32'(bus.almost_full), 32'h1);
      if (i == 14) check("full_at15", 32'(bus.full), 32'h0);
    end
    check("full_at16", 32'(bus.full), 32'h1);
    check("count_16", 32'(bus.count), 32'd16);

    // Extra push while full: rejected, overflow set, contents unchanged.
    drive(1, 8'hAA, 0, 0);
    check("ovf_set", 32'(bus.overflow), 32'h1);
    check("ovf_count", 32'(bus.count), 32'd16);
    check("ovf_head", 32'(bus.rd_data), 32'h00);

    // Drain: head sequence 0x00..0x0F, one per cycle.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk_in);
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b1;
      #1 check("drain_data", 32'(bus.rd_data), 32'(i));
      @(posedge clk_in);
      #1;
      if (i == 12) check("ae_at3", 32'(bus.almost_empty), 32'h0);
      if (i == 13) check("ae_at2", 32'(bus.almost_empty), 32'h1);
    end
    check("drain_empty", 32'(bus.empty), 32'h1);
    check("drain_count", 32'(bus.count), 32'h0);
    drive(0, 8'h00, 0, 1);

    // Steady state at count 5 with pointer wrap.
    for (int i = 0; i < 5; i++) drive(1, 8'h50 + DW'(i), 0, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'h60 + DW'(i);
      bus.rd_en   = 1'b1;
      #1 check("stream_data", 32'(bus.rd_data),
               (i < 5) ? 32'(8'h50 + i) : 32'(8'h60 + i - 5));
      @(posedge clk_in);
      #1 check("stream_count", 32'(bus.count), 32'd5);
    end
    for (int i = 0; i < 5; i++) drive(0, 8'h00, 1, 0);
    check("stream_tail_empty", 32'(bus.empty), 32'h1);
    check("stream_no_err", 32'(bus.underflow | bus.overflow), 32'h0);

    // Push and pop together while empty: push wins, pop is an underflow.
    drive(1, 8'hC3, 1, 0);
    check("sim_unf", 32'(bus.underflow), 32'h1);
    check("sim_count", 32'(bus.count), 32'h1);
    check("sim_rd", 32'(bus.rd_data), 32'hC3);

    // Grow to 7 entries, then flush alongside a push.
    for (int i = 0; i < 6; i++) drive(1, 8'h70 + DW'(i), 0, 0);
    check("pre_flush_count", 32'(bus.count), 32'd7);
    drive(1, 8'hEE, 0, 1);
    check("flush_count", 32'(bus.count), 32'h0);
    check("flush_empty", 32'(bus.empty), 32'h1);
    check("flush_unf", 32'(bus.underflow), 32'h0);
    check("flush_ovf", 32'(bus.overflow), 32'h0);
    drive(1, 8'h3C, 0, 0);
    check("post_flush_rd", 32'(bus.rd_data), 32'h3C);

    // Asynchronous reset in the middle of a push burst.
    drive(1, 8'h11, 0, 0);
    drive(1, 8'h22, 0, 0);
    @(negedge clk_in);
    bus.wr_data = 8'h33;
    #2 n_rst = 1'b0;
    #1 check_reset_values("async_rst");
    bus.wr_en = 1'b0;
    @(negedge clk_in);
    n_rst = 1'b1;
    drive(0, 8'h00, 0, 0);
    check_reset_values("after_rst");
    drive(0, 8'h00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sync_fifo
